// File: rtl/pid_reg_pkg.sv
// Shared constants and saturation helpers for the memory-mapped PID regulator.
package pid_reg_pkg;

    localparam logic [3:0] ADDR_KP        = 4'd0;
    localparam logic [3:0] ADDR_KI        = 4'd1;
    localparam logic [3:0] ADDR_KD        = 4'd2;
    localparam logic [3:0] ADDR_PRESCALER = 4'd3;
    localparam logic [3:0] ADDR_FEEDBACK  = 4'd4;
    localparam logic [3:0] ADDR_CTRL      = 4'd6;
    localparam logic [3:0] ADDR_SETPOINT  = 4'd10;
    localparam logic [3:0] ADDR_SHIFT     = 4'd11;
    localparam logic [3:0] ADDR_CONTROL   = 4'd12;
    localparam logic [3:0] ADDR_ERROR     = 4'd13;
    localparam logic [3:0] ADDR_INTEGRAL  = 4'd14;
    localparam logic [3:0] ADDR_ID        = 4'd15;

    localparam logic [31:0] PID_ID = 32'h0000_91D0;

    localparam int CTRL_RUN   = 0;
    localparam int CTRL_FBSEL = 1;

    // Three 64-bit products summed need two guard bits.
    localparam int SUM_W = 66;
    localparam logic signed [SUM_W-1:0] SUM_MAX = 66'sd2147483647;
    localparam logic signed [SUM_W-1:0] SUM_MIN = -66'sd2147483648;

    function automatic logic signed [31:0] sat33(input logic signed [32:0] v);
        if (v[32] != v[31])
            return v[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
        return v[31:0];
    endfunction

    function automatic logic signed [31:0] sat_sum(input logic signed [SUM_W-1:0] v);
        if (v > SUM_MAX)
            return 32'sh7FFF_FFFF;
        if (v < SUM_MIN)
            return 32'sh8000_0000;
        return v[31:0];
    endfunction

endpackage

// File: rtl/pid_reg_core.sv
// PID datapath: prescaled tick counter, single-cycle update and loop state.
module pid_core
    import pid_reg_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               run,
    input  logic               fbsel,
    input  logic               stop,
    input  logic               ctrl_wr,
    input  logic               presc_wr,
    input  logic        [31:0] prescaler,
    input  logic signed [31:0] kp,
    input  logic signed [31:0] ki,
    input  logic signed [31:0] kd,
    input  logic signed [31:0] feedback_reg,
    input  logic signed [31:0] feedback_bypass,
    input  logic signed [31:0] setpoint,
    input  logic        [4:0]  shift,
    output logic signed [31:0] control,
    output logic signed [31:0] error,
    output logic signed [31:0] integral
);

    logic        [31:0] cnt;
    logic        [31:0] period_m1;
    logic               terminal;
    logic               tick;
    logic signed [31:0] prev_e;

    logic signed [31:0]       fb;
    logic signed [31:0]       e;
    logic signed [31:0]       i_next;
    logic signed [31:0]       d;
    logic signed [31:0]       control_next;
    logic signed [SUM_W-1:0]  kp_w, ki_w, kd_w, e_w, i_w, d_w;
    logic signed [SUM_W-1:0]  sum;
    logic signed [SUM_W-1:0]  shifted;

    // A prescaler of zero behaves like one: tick on every enabled cycle.
    assign period_m1 = (prescaler == 32'd0) ? 32'd0 : prescaler - 32'd1;
    assign terminal  = (cnt >= period_m1);
    assign tick      = en && run && terminal && !ctrl_wr;

    always_comb begin
        fb     = fbsel ? feedback_bypass : feedback_reg;
        e      = sat33($signed({setpoint[31], setpoint}) - $signed({fb[31], fb}));
        i_next = sat33($signed({integral[31], integral}) + $signed({e[31], e}));
        d      = sat33($signed({e[31], e}) - $signed({prev_e[31], prev_e}));

        kp_w = {{(SUM_W-32){kp[31]}}, kp};
        ki_w = {{(SUM_W-32){ki[31]}}, ki};
        kd_w = {{(SUM_W-32){kd[31]}}, kd};
        e_w  = {{(SUM_W-32){e[31]}}, e};
        i_w  = {{(SUM_W-32){i_next[31]}}, i_next};
        d_w  = {{(SUM_W-32){d[31]}}, d};

        sum          = kp_w * e_w + ki_w * i_w + kd_w * d_w;
        shifted      = sum >>> shift;
        control_next = sat_sum(shifted);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            prev_e   <= '0;
            error    <= '0;
            integral <= '0;
            control  <= '0;
        end else begin
            if (stop || presc_wr)
                cnt <= '0;
            else if (en && run)
                cnt <= terminal ? 32'd0 : cnt + 32'd1;

            // Stopping clears the loop memory but leaves the last output driven.
            if (stop) begin
                integral <= '0;
                prev_e   <= '0;
            end else if (tick) begin
                error    <= e;
                integral <= i_next;
                prev_e   <= e;
                control  <= control_next;
            end
        end
    end

endmodule

// File: rtl/pid_reg.sv
// Bus-facing register file for the PID regulator; arithmetic lives in pid_core.
module pid_reg
    import pid_reg_pkg::*;
#(
    parameter logic [31:0] PRESCALER_DEFAULT_VALUE = 32'd1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               chipSelect,
    input  logic               write,
    input  logic               read,
    input  logic        [3:0]  addr,
    input  logic        [31:0] writeData,
    input  logic signed [31:0] feedback_bypass,
    output logic        [31:0] readData,
    output logic signed [31:0] control_bypass
);

    logic signed [31:0] kp, ki, kd, feedback, setpoint;
    logic        [31:0] prescaler;
    logic        [1:0]  ctrl;
    logic        [4:0]  shift;
    logic signed [31:0] control, error, integral;

    logic        wr;
    logic        ctrl_wr;
    logic        stop;
    logic        presc_wr;
    logic [31:0] rd_mux;

    assign wr       = chipSelect && write && en;
    assign ctrl_wr  = wr && (addr == ADDR_CTRL);
    assign stop     = ctrl_wr && !writeData[CTRL_RUN];
    assign presc_wr = wr && (addr == ADDR_PRESCALER);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kp        <= '0;
            ki        <= '0;
            kd        <= '0;
            prescaler <= PRESCALER_DEFAULT_VALUE;
            feedback  <= '0;
            ctrl      <= '0;
            setpoint  <= '0;
            shift     <= '0;
        end else if (wr) begin
            case (addr)
                ADDR_KP:        kp        <= writeData;
                ADDR_KI:        ki        <= writeData;
                ADDR_KD:        kd        <= writeData;
                ADDR_PRESCALER: prescaler <= writeData;
                ADDR_FEEDBACK:  feedback  <= writeData;
                ADDR_CTRL:      ctrl      <= writeData[1:0];
                ADDR_SETPOINT:  setpoint  <= writeData;
                ADDR_SHIFT:     shift     <= writeData[4:0];
                default:        ;
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        case (addr)
            ADDR_KP:        rd_mux = kp;
            ADDR_KI:        rd_mux = ki;
            ADDR_KD:        rd_mux = kd;
            ADDR_PRESCALER: rd_mux = prescaler;
            ADDR_FEEDBACK:  rd_mux = feedback;
            ADDR_CTRL:      rd_mux = {30'd0, ctrl};
            ADDR_SETPOINT:  rd_mux = setpoint;
            ADDR_SHIFT:     rd_mux = {27'd0, shift};
            ADDR_CONTROL:   rd_mux = control;
            ADDR_ERROR:     rd_mux = error;
            ADDR_INTEGRAL:  rd_mux = integral;
            ADDR_ID:        rd_mux = PID_ID;
            default:        rd_mux = '0;
        endcase
    end

    // Registers are sampled before the edge, so a same-cycle write is not visible.
    assign readData       = (chipSelect && read) ? rd_mux : 32'd0;
    assign control_bypass = control;

    pid_core u_core (
        .clk             (clk),
        .rst             (rst),
        .en              (en),
        .run             (ctrl[CTRL_RUN]),
        .fbsel           (ctrl[CTRL_FBSEL]),
        .stop            (stop),
        .ctrl_wr         (ctrl_wr),
        .presc_wr        (presc_wr),
        .prescaler       (prescaler),
        .kp              (kp),
        .ki              (ki),
        .kd              (kd),
        .feedback_reg    (feedback),
        .feedback_bypass (feedback_bypass),
        .setpoint        (setpoint),
        .shift           (shift),
        .control         (control),
        .error           (error),
        .integral        (integral)
    );

endmodule

// File: tb/tb_pid_reg.sv
// Directed bench for pid_reg: expected values queued at stimulus time, popped at each sample.
module tb_pid_reg;
    import pid_reg_pkg::*;

    logic               clk;
    logic               rst;
    logic               en;
    logic               chipSelect;
    logic               write;
    logic               read;
    logic        [3:0]  addr;
    logic        [31:0] writeData;
    logic signed [31:0] feedback_bypass;
    logic        [31:0] readData;
    logic signed [31:0] control_bypass;

    int vectors     = 0;
    int miscompares = 0;
    logic [31:0] exp_q[$];

    pid_reg #(.PRESCALER_DEFAULT_VALUE(32'd1)) dut (
        .clk             (clk),
        .rst             (rst),
        .en              (en),
        .chipSelect      (chipSelect),
        .write           (write),
        .read            (read),
        .addr            (addr),
        .writeData       (writeData),
        .feedback_bypass (feedback_bypass),
        .readData        (readData),
        .control_bypass  (control_bypass)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic compare(input string tag, input logic [31:0] obs);
        logic [31:0] expv;
        expv = exp_q.pop_front();
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] expv, input string tag);
        @(negedge clk);
        chipSelect = 1'b1;
        read       = 1'b1;
        addr       = a;
        exp_q.push_back(expv);
        #2;
        compare(tag, readData);
        read       = 1'b0;
        chipSelect = 1'b0;
    endtask

    task automatic chk_bypass(input logic [31:0] expv, input string tag);
        exp_q.push_back(expv);
        #1;
        compare(tag, control_bypass);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        en         = 1'b1;
        chipSelect = 1'b1;
        write      = 1'b1;
        addr       = a;
        writeData  = d;
        @(negedge clk);
        write      = 1'b0;
        chipSelect = 1'b0;
        en         = 1'b0;
    endtask

    task automatic run(input int n);
        @(negedge clk);
        en = 1'b1;
        repeat (n) @(negedge clk);
        en = 1'b0;
    endtask

    function automatic logic [31:0] reset_value(input logic [3:0] a);
        if (a == ADDR_PRESCALER) return 32'd1;
        if (a == ADDR_ID)        return PID_ID;
        return 32'd0;
    endfunction

    initial begin
        rst = 1'b0; en = 1'b0; chipSelect = 1'b0; write = 1'b0; read = 1'b0;
        addr = '0; writeData = '0; feedback_bypass = '0;

        // Reads stay live while reset is held.
        rd(ADDR_ID, PID_ID, "id_in_reset");
        chk_bypass(32'd0, "bypass_in_reset");
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 16; i++)
            rd(4'(i), reset_value(4'(i)), $sformatf("reset_addr%0d", i));
        chk_bypass(32'd0, "bypass_after_reset");

        // Same-cycle read and write returns the old value.
        @(negedge clk);
        en = 1'b1; chipSelect = 1'b1; write = 1'b1; read = 1'b1;
        addr = ADDR_SETPOINT; writeData = 32'd15;
        exp_q.push_back(32'd0);
        #2;
        compare("raw_setpoint_old", readData);
        @(negedge clk);
        en = 1'b0; chipSelect = 1'b0; write = 1'b0; read = 1'b0;
        rd(ADDR_SETPOINT, 32'd15, "setpoint_rb");

        wr(ADDR_KP, 32'd20);
        wr(ADDR_KI, 32'd1);
        wr(ADDR_KD, 32'hFFFF_FFFF);
        wr(ADDR_SHIFT, 32'hFFFF_FFE5);
        wr(4'd5, 32'h1234_5678);
        wr(ADDR_ID, 32'h0);
        rd(ADDR_KP, 32'd20, "kp_rb");
        rd(ADDR_KI, 32'd1, "ki_rb");
        rd(ADDR_KD, 32'hFFFF_FFFF, "kd_rb");
        rd(ADDR_SHIFT, 32'd5, "shift_masked");
        rd(4'd5, 32'd0, "reserved_ignored");
        rd(ADDR_ID, PID_ID, "id_ro");

        // Prescaler 2 lets a register write land between ticks.
        wr(ADDR_PRESCALER, 32'd2);
        wr(ADDR_FEEDBACK, 32'd0);
        wr(ADDR_CTRL, 32'd1);
        run(1);
        rd(ADDR_ERROR, 32'd0, "no_tick_yet");
        run(1);
        rd(ADDR_ERROR, 32'd15, "tick1_error");
        rd(ADDR_INTEGRAL, 32'd15, "tick1_integral");
        rd(ADDR_CONTROL, 32'd9, "tick1_control");
        chk_bypass(32'd9, "tick1_bypass");

        wr(ADDR_FEEDBACK, 32'd1);
        rd(ADDR_ERROR, 32'd15, "fb_write_no_tick");
        run(1);
        rd(ADDR_ERROR, 32'd14, "tick2_error");
        rd(ADDR_INTEGRAL, 32'd29, "tick2_integral");
        rd(ADDR_CONTROL, 32'd9, "tick2_control");

        // Bypass feedback, prescaler 4: e=-4, I=25, d=-18, sum=-37 -> floor(-37/32)=-2.
        wr(ADDR_PRESCALER, 32'd4);
        feedback_bypass = 32'sd19;
        wr(ADDR_CTRL, 32'd3);
        rd(ADDR_CTRL, 32'd3, "ctrl_rb");
        run(2);
        rd(ADDR_ERROR, 32'd14, "presc4_3rd_clock");
        run(1);
        rd(ADDR_ERROR, 32'hFFFF_FFFC, "bypass_error");
        rd(ADDR_INTEGRAL, 32'd25, "bypass_integral");
        rd(ADDR_CONTROL, 32'hFFFF_FFFE, "bypass_control_floor");
        run(3);
        rd(ADDR_INTEGRAL, 32'd25, "presc4_hold");
        run(1);
        rd(ADDR_INTEGRAL, 32'd21, "presc4_next_tick");

        // A CTRL write in a tick cycle suppresses the update.
        wr(ADDR_PRESCALER, 32'd1);
        wr(ADDR_CTRL, 32'd3);
        rd(ADDR_INTEGRAL, 32'd21, "ctrl_write_priority");
        repeat (5) @(negedge clk);
        rd(ADDR_INTEGRAL, 32'd21, "en_low_freeze");
        run(1);
        rd(ADDR_INTEGRAL, 32'd17, "resume_tick");

        wr(ADDR_CTRL, 32'd0);
        rd(ADDR_INTEGRAL, 32'd0, "stop_clears_integral");
        rd(ADDR_CONTROL, 32'hFFFF_FFFE, "stop_holds_control");

        // Positive saturation of error, integral and output.
        wr(ADDR_KP, 32'h7FFF_FFFF);
        wr(ADDR_SHIFT, 32'd0);
        wr(ADDR_SETPOINT, 32'h7FFF_FFF0);
        wr(ADDR_FEEDBACK, 32'hFFFF_FC18);
        wr(ADDR_CTRL, 32'd1);
        run(1);
        rd(ADDR_ERROR, 32'h7FFF_FFFF, "sat_pos_error");
        rd(ADDR_CONTROL, 32'h7FFF_FFFF, "sat_pos_control");
        wr(ADDR_CTRL, 32'd0);
        rd(ADDR_INTEGRAL, 32'd0, "stop2_integral");
        rd(ADDR_CONTROL, 32'h7FFF_FFFF, "stop2_control_hold");

        // Negative saturation, then integral pinned at the minimum.
        wr(ADDR_SETPOINT, 32'h8000_0000);
        wr(ADDR_FEEDBACK, 32'd1000);
        wr(ADDR_CTRL, 32'd1);
        run(1);
        rd(ADDR_ERROR, 32'h8000_0000, "sat_neg_error");
        rd(ADDR_CONTROL, 32'h8000_0000, "sat_neg_control");
        run(1);
        rd(ADDR_INTEGRAL, 32'h8000_0000, "sat_neg_integral");

        // Reset asserted while updates are running.
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk_bypass(32'd0, "midreset_bypass");
        rd(ADDR_ERROR, 32'd0, "midreset_error");
        rd(ADDR_PRESCALER, 32'd1, "midreset_prescaler");
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b0;
        rd(ADDR_KP, 32'd0, "post_reset_kp");
        rd(ADDR_INTEGRAL, 32'd0, "post_reset_integral");
        rd(ADDR_CONTROL, 32'd0, "post_reset_control");
        rd(ADDR_CTRL, 32'd0, "post_reset_ctrl");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
